// File: rtl/pipelined_logic_unit.sv
// pipelined_logic_unit: parametrised bitwise logic unit with a STAGES-deep valid/ready pipe and Z/N flags
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   in_valid/in_ready       input handshake; a, b, op, set_flags, in_tag travel with it
//   flush                   kills every in-flight entry on the next edge
//   out_valid/out_ready     output handshake; result and out_tag come from the last stage
//   flag_z, flag_n          zero/negative flags, updated only when a set_flags entry retires
module pipelined_logic_unit #(
    parameter int WIDTH  = 64,
    parameter int STAGES = 2,
    parameter int TAG_W  = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    input  logic             set_flags,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [TAG_W-1:0] out_tag,
    output logic             flag_z,
    output logic             flag_n
);
    logic [STAGES-1:0] vld, sf, adv;
    logic [WIDTH-1:0]  dat [STAGES];
    logic [TAG_W-1:0]  tg  [STAGES];
    logic [WIDTH-1:0]  fn_out;
    logic              go;

    always_comb begin
        case (op)
            3'b000:  fn_out = a & b;
            3'b001:  fn_out = a | b;
            3'b010:  fn_out = a ^ b;
            3'b011:  fn_out = a & ~b;
            3'b100:  fn_out = a | ~b;
            3'b101:  fn_out = ~(a ^ b);
            3'b110:  fn_out = a;
            default: fn_out = ~b;
        endcase
    end

    // A stage moves when it is empty or everything downstream moves, so bubbles collapse.
    always_comb begin
        adv = '0;
        go  = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            go     = !vld[k] | go;
            adv[k] = go;
        end
    end

    assign in_ready  = adv[0] & ~flush;
    assign out_valid = vld[STAGES-1];
    assign result    = dat[STAGES-1];
    assign out_tag   = tg[STAGES-1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld    <= '0;
            sf     <= '0;
            flag_z <= 1'b0;
            flag_n <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                dat[k] <= '0;
                tg[k]  <= '0;
            end
        end else begin
            if (adv[0]) begin
                vld[0] <= in_valid & in_ready;
                dat[0] <= fn_out;
                tg[0]  <= in_tag;
                sf[0]  <= set_flags;
            end
            for (int k = 1; k < STAGES; k++) begin
                if (adv[k]) begin
                    vld[k] <= vld[k-1];
                    dat[k] <= dat[k-1];
                    tg[k]  <= tg[k-1];
                    sf[k]  <= sf[k-1];
                end
            end
            if (flush)
                vld <= '0;
            // A retiring entry still updates the flags even when flush is high.
            if (out_valid & out_ready & sf[STAGES-1]) begin
                flag_z <= (result == '0);
                flag_n <= result[WIDTH-1];
            end
        end
    end
endmodule

// File: tb/tb_pipelined_logic_unit.sv
// tb_pipelined_logic_unit: randomized and directed self-checking bench against a queue-based reference model
module tb_pipelined_logic_unit;
    localparam int S = 2;

    logic        clk = 1'b0, reset_n = 1'b0;
    logic        in_valid = 1'b0, set_flags = 1'b0, flush = 1'b0, out_ready = 1'b0;
    logic [63:0] a = '0, b = '0;
    logic [2:0]  op = '0;
    logic [4:0]  in_tag = '0;
    logic        in_ready, out_valid, flag_z, flag_n;
    logic [63:0] result;
    logic [4:0]  out_tag;

    pipelined_logic_unit #(.WIDTH(64), .STAGES(S), .TAG_W(5)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .set_flags(set_flags), .in_tag(in_tag), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .result(result), .out_tag(out_tag),
        .flag_z(flag_z), .flag_n(flag_n)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] res;
        logic [4:0]  tag;
        logic        sf;
        int          acc;
    } ent_t;

    ent_t        q[$];
    logic [63:0] got[$];
    int          n_cmp = 0, n_bad = 0, cyc = 0;
    logic        mz = 1'b0, mn = 1'b0, accepted = 1'b0;
    logic [7:0]  exp8 [8] = '{8'h24, 8'hBD, 8'h99, 8'h81, 8'hE7, 8'h66, 8'hA5, 8'hC3};

    function automatic logic [63:0] ref_op(input logic [2:0] o, input logic [63:0] x, input logic [63:0] y);
        case (o)
            3'd0: return x & y;
            3'd1: return x | y;
            3'd2: return x ^ y;
            3'd3: return x & ~y;
            3'd4: return x | ~y;
            3'd5: return ~(x ^ y);
            3'd6: return x;
            default: return ~y;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", nm, obs, exp);
        end
    endtask

    // One clock: check handshake/outputs before the edge, advance the model, check flags after it.
    task automatic tick();
        logic xr, xov, hs, ac;
        ent_t e;
        #1;
        xr  = !flush && !(q.size() == S && !out_ready);
        xov = q.size() > 0 && (cyc - q[0].acc >= S);
        chk("in_ready", in_ready, xr);
        chk("out_valid", out_valid, xov);
        if (xov) begin
            chk("result", result, q[0].res);
            chk("out_tag", out_tag, q[0].tag);
        end
        hs = xov && out_ready;
        ac = in_valid && xr;
        @(posedge clk);
        if (hs) begin
            e = q.pop_front();
            if (e.sf) begin
                mz = (e.res == 0);
                mn = e.res[63];
            end
            got.push_back(e.res);
        end
        if (flush) q.delete();
        if (ac) q.push_back('{res: ref_op(op, a, b), tag: in_tag, sf: set_flags, acc: cyc});
        cyc++;
        accepted = ac;
        #1;
        chk("flag_z", flag_z, mz);
        chk("flag_n", flag_n, mn);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send(input logic [63:0] va, input logic [63:0] vb, input logic [2:0] vo,
                        input logic vs, input logic [4:0] vt);
        a = va; b = vb; op = vo; set_flags = vs; in_tag = vt; in_valid = 1'b1;
        accepted = 1'b0;
        for (int i = 0; i < 20 && !accepted; i++) tick();
        chk("send_accepted", accepted, 1'b1);
        in_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $error("FAIL watchdog: observed timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [63:0] r0;
        int c0;
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_out_tag", out_tag, 0);
        chk("rst_flag_z", flag_z, 0);
        chk("rst_flag_n", flag_n, 0);
        @(negedge clk);
        reset_n = 1'b1;

        // 64-bit AND vector, latency 2
        out_ready = 1'b1;
        got.delete();
        send(64'hF0F0_0000_0000_FFFF, 64'hFF00_0000_0000_0F0F, 3'b000, 1'b0, 5'd3);
        chk("vec_lat1", out_valid, 0);
        tick();
        chk("vec_lat2", out_valid, 1);
        chk("vec_result", result, 64'hF000_0000_0000_0F0F);
        chk("vec_tag", out_tag, 5'd3);
        idle(2);

        // all ops back to back
        got.delete();
        c0 = cyc;
        for (int i = 0; i < 8; i++) send(64'hA5, 64'h3C, 3'(i), 1'b0, 5'(i));
        chk("sweep_issue_cycles", cyc - c0, 8);
        idle(3);
        chk("sweep_count", got.size(), 8);
        for (int i = 0; i < 8; i++) chk("sweep_low_byte", got[i][7:0], exp8[i]);

        // flags
        send(64'h5, 64'hA, 3'b000, 1'b1, 5'd1);
        idle(3);
        chk("flags_and_z", flag_z, 1);
        chk("flags_and_n", flag_n, 0);
        send(64'h5, 64'hA, 3'b001, 1'b0, 5'd2);
        idle(3);
        chk("flags_hold_z", flag_z, 1);
        chk("flags_hold_n", flag_n, 0);

        // backpressure
        out_ready = 1'b0;
        got.delete();
        send(64'h11, 64'h0, 3'b110, 1'b0, 5'd1);
        send(64'h22, 64'h0, 3'b110, 1'b0, 5'd2);
        a = 64'h33; op = 3'b110; in_tag = 5'd3; in_valid = 1'b1;
        idle(1);
        r0 = result;
        idle(3);
        chk("bp_in_ready", in_ready, 0);
        chk("bp_result_stable", result, r0);
        chk("bp_tag_stable", out_tag, 5'd1);
        out_ready = 1'b1;
        send(64'h33, 64'h0, 3'b110, 1'b0, 5'd3);
        send(64'h44, 64'h0, 3'b110, 1'b0, 5'd4);
        idle(4);
        chk("bp_count", got.size(), 4);
        for (int i = 0; i < 4; i++) chk("bp_order", got[i], 64'((i + 1) * 17));

        // flush with a concurrent input
        out_ready = 1'b0;
        send(64'h1, 64'h0, 3'b110, 1'b1, 5'd5);
        send(64'h2, 64'h0, 3'b110, 1'b1, 5'd6);
        a = 64'h3; in_tag = 5'd7; in_valid = 1'b1; flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_out_valid", out_valid, 0);
        chk("flush_flag_z", flag_z, 1);
        idle(3);
        out_ready = 1'b1;

        // random traffic
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom % 4) != 0;
            a         = {$urandom, $urandom};
            b         = ($urandom % 8 == 0) ? a : {$urandom, $urandom};
            op        = 3'($urandom);
            set_flags = 1'($urandom);
            in_tag    = 5'($urandom);
            out_ready = ($urandom % 4) != 0;
            flush     = ($urandom % 25) == 0;
            tick();
        end
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        idle(4);

        // async reset mid-stream
        send(64'h8000_0000_0000_0000, 64'h0, 3'b110, 1'b1, 5'd9);
        idle(3);
        chk("pre_rst_flag_n", flag_n, 1);
        out_ready = 1'b0;
        send(64'h7, 64'h0, 3'b110, 1'b1, 5'd10);
        send(64'h8, 64'h0, 3'b110, 1'b1, 5'd11);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_result", result, 0);
        chk("arst_flag_n", flag_n, 0);
        chk("arst_flag_z", flag_z, 0);
        q.delete(); mz = 1'b0; mn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        out_ready = 1'b1;
        send(64'hC, 64'h6, 3'b010, 1'b1, 5'd12);
        chk("post_rst_lat1", out_valid, 0);
        tick();
        chk("post_rst_lat2", out_valid, 1);
        chk("post_rst_result", result, 64'hA);
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
